// File: rtl/mac_tap_sequencer_if.sv
// mac_tap_sequencer_if: sample input stream, coefficient write port, shared MAC
// operand/result lines and filtered-result output stream of the tap sequencer.
// With MACSEQ_SAT_EN defined the interface also carries the sticky sat_flag.
interface mac_tap_sequencer_if #(
   parameter int IDX_W = 3
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [24:0]      in_data;
   logic                    coef_wr;
   logic [IDX_W-1:0]        coef_addr;
   logic signed [17:0]      coef_data;
   logic                    coef_busy;
   logic signed [24:0]      mac_a;
   logic signed [17:0]      mac_b;
   logic signed [47:0]      mac_c;
   logic signed [47:0]      mac_out;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [47:0]      out_data;
`ifdef MACSEQ_SAT_EN
   logic                    sat_flag;
`endif

   // environment side: feeds samples/coefficients, computes the MAC, takes results
   modport master (
      output in_valid, in_data, coef_wr, coef_addr, coef_data, mac_out, out_ready,
      input  in_ready, coef_busy, mac_a, mac_b, mac_c, out_valid, out_data
`ifdef MACSEQ_SAT_EN
      , input sat_flag
`endif
   );

   // sequencer side
   modport slave (
      input  in_valid, in_data, coef_wr, coef_addr, coef_data, mac_out, out_ready,
      output in_ready, coef_busy, mac_a, mac_b, mac_c, out_valid, out_data
`ifdef MACSEQ_SAT_EN
      , output sat_flag
`endif
   );
endinterface

// File: rtl/mac_tap_sequencer.sv
// mac_tap_sequencer: steps one external 25x18+48 MAC through NTAPS FIR taps per
// accepted sample, using a circular delay line and a writable coefficient bank.
// Optional macro MACSEQ_SAT_EN clamps the result to SAT_W bits and adds a
// sticky sat_flag output.
module mac_tap_sequencer #(
   parameter int NTAPS = 8,
   parameter int IDX_W = $clog2(NTAPS),
   parameter int SAT_W = 32
) (
   input logic                clk,
   input logic                rst,
   mac_tap_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(NTAPS - 1);

   if (NTAPS < 2 || NTAPS > 64 || (NTAPS & (NTAPS - 1)) != 0 ||
       SAT_W < 2 || SAT_W > 48) begin : g_param_check
      $error("mac_tap_sequencer: unsupported NTAPS or SAT_W");
   end

   state_t             state;
   state_t             state_next;
   logic signed [24:0] sample [NTAPS];
   logic signed [17:0] coef   [NTAPS];
   logic [IDX_W-1:0]   wr_ptr;
   logic [IDX_W-1:0]   base;
   logic [IDX_W-1:0]   k;
   logic [IDX_W-1:0]   tap;
   logic signed [47:0] acc;
   logic signed [47:0] result;
   logic               accept;
   logic               coef_we;
   logic               last_tap;

   // Samples and coefficients may only change while idle, so a run always sees
   // a frozen delay line and coefficient bank.
   assign accept   = (state == IDLE) && bus.in_valid;
   assign coef_we  = (state == IDLE) && bus.coef_wr;
   assign last_tap = (k == K_LAST);
   // Delay line is walked backwards from the newest sample; power-of-two NTAPS
   // makes the index wrap for free.
   assign tap      = base - k;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake/operand outputs; the MAC sees zeros unless running
   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.coef_busy = 1'b1;
      bus.out_valid = 1'b0;
      bus.mac_a     = '0;
      bus.mac_b     = '0;
      bus.mac_c     = '0;
      case (state)
         IDLE: begin
            bus.in_ready  = 1'b1;
            bus.coef_busy = 1'b0;
            if (bus.in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            bus.mac_a = sample[tap];
            bus.mac_b = coef[k];
            bus.mac_c = acc;
            if (last_tap) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Delay-line and coefficient storage, both written only while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            sample[i] <= '0;
            coef[i]   <= '0;
         end
      end else begin
         if (accept) begin
            sample[wr_ptr] <= bus.in_data;
         end
         if (coef_we) begin
            coef[bus.coef_addr] <= bus.coef_data;
         end
      end
   end

   // Pointers and accumulator: a new sample restarts the tap walk, each RUN
   // cycle folds one product into acc
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         base   <= '0;
         k      <= '0;
         acc    <= '0;
      end else if (accept) begin
         base   <= wr_ptr;
         wr_ptr <= wr_ptr + IDX_ONE;
         k      <= '0;
         acc    <= '0;
      end else if (state == RUN) begin
         acc <= bus.mac_out;
         k   <= k + IDX_ONE;
      end
   end

`ifdef MACSEQ_SAT_EN
   localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (SAT_W - 1)) - 48'sd1;
   localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (SAT_W - 1));

   logic sat_flag;
   logic clamp_now;

   // The final accumulate happens on the last RUN cycle; judge the value that
   // is about to land in acc so the flag rises together with DONE
   assign clamp_now = (state == RUN) && last_tap &&
                      ((bus.mac_out > SAT_MAX) || (bus.mac_out < SAT_MIN));

   // Clamp the finished sum into the SAT_W range, kept sign-extended to 48 bits
   always_comb begin
      result = acc;
      if (acc > SAT_MAX) begin
         result = SAT_MAX;
      end else if (acc < SAT_MIN) begin
         result = SAT_MIN;
      end
   end

   // Sticky saturation indicator, only a reset clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag <= 1'b0;
      end else if (clamp_now) begin
         sat_flag <= 1'b1;
      end
   end

   assign bus.sat_flag = sat_flag;
`else
   assign result = acc;
`endif

   // Result is only presented while a finished sum is waiting to be taken
   assign bus.out_data = (state == DONE) ? result : '0;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb_mac_tap_sequencer: directed and randomized checks of mac_tap_sequencer
// against a sum-of-products reference model of the FIR. The bench supplies the
// combinational MAC. Honours MACSEQ_SAT_EN when defined.
module tb_mac_tap_sequencer;

   localparam int NTAPS = 8;
   localparam int IDX_W = 3;
   localparam int SAT_W = 32;
`ifdef MACSEQ_SAT_EN
   localparam longint SMAX = (longint'(1) <<< (SAT_W - 1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (SAT_W - 1));
`endif

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     vectors = 0;
   int     miscompares = 0;
   int     mcoef [NTAPS];
   longint hist [$];
   bit     sat_model = 1'b0;

   mac_tap_sequencer_if #(.IDX_W(IDX_W)) bus ();

   mac_tap_sequencer #(.NTAPS(NTAPS), .IDX_W(IDX_W), .SAT_W(SAT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Combinational MAC: sign-extend both operands to 48 bits, multiply, add
   assign bus.mac_out = ({{23{bus.mac_a[24]}}, bus.mac_a} *
                         {{30{bus.mac_b[17]}}, bus.mac_b}) + bus.mac_c;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [47:0] obs,
                              input logic [47:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sext18(input int v);
      logic signed [17:0] c;
      c = 18'(v);
      return int'(c);
   endfunction

   function automatic int rnd25();
      logic signed [24:0] r;
      r = 25'($urandom);
      return int'(r);
   endfunction

   // Reference: y[n] = sum_k coef[k] * x[n-k], missing history counts as zero
   function automatic logic [47:0] model_result(output bit clamped);
      longint sum;
      sum = 0;
      clamped = 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
         if (i < hist.size()) begin
            sum += longint'(mcoef[i]) * hist[i];
         end
      end
`ifdef MACSEQ_SAT_EN
      if (sum > SMAX) begin
         sum = SMAX;
         clamped = 1'b1;
      end else if (sum < SMIN) begin
         sum = SMIN;
         clamped = 1'b1;
      end
`endif
      return sum[47:0];
   endfunction

   task automatic applyReset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.coef_wr = 1'b0;
      bus.out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      hist.delete();
      for (int i = 0; i < NTAPS; i++) mcoef[i] = 0;
      sat_model = 1'b0;
   endtask

   task automatic checkReset();
      checkOutput("rst_in_ready", 48'(bus.in_ready), 48'(1));
      checkOutput("rst_coef_busy", 48'(bus.coef_busy), 48'(0));
      checkOutput("rst_out_valid", 48'(bus.out_valid), 48'(0));
      checkOutput("rst_out_data", bus.out_data, 48'(0));
      checkOutput("rst_mac_a", 48'(bus.mac_a), 48'(0));
      checkOutput("rst_mac_b", 48'(bus.mac_b), 48'(0));
      checkOutput("rst_mac_c", bus.mac_c, 48'(0));
`ifdef MACSEQ_SAT_EN
      checkOutput("rst_sat_flag", 48'(bus.sat_flag), 48'(0));
`endif
   endtask

   // Coefficient write issued while the sequencer is idle
   task automatic writeCoef(input int addr, input int val);
      bus.coef_wr = 1'b1;
      bus.coef_addr = IDX_W'(addr);
      bus.coef_data = 18'(val);
      step();
      bus.coef_wr = 1'b0;
      mcoef[addr] = sext18(val);
   endtask

   // One sample through the sequencer. wr_mode: 0 none, 1 coefficient write in
   // the accept cycle (takes effect), 2 coefficient write in the first RUN
   // cycle (must be ignored). stall = cycles out_ready is held low in DONE.
   task automatic applyStimulus(input int data, input int stall, input int wr_mode,
                                input int wr_addr, input int wr_val,
                                output logic [47:0] got);
      logic signed [24:0] d25;
      logic [47:0]        exp;
      bit                 clamped;
      int                 lat;
      got = '0;
      d25 = 25'(data);
      lat = 0;
      while (bus.in_ready !== 1'b1 && lat < 50) begin
         step();
         lat++;
      end
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $error("[TB] FAIL accept_timeout: in_ready %b required 1", bus.in_ready);
         return;
      end
      bus.out_ready = (stall == 0);
      bus.in_data = d25;
      bus.in_valid = 1'b1;
      if (wr_mode == 1) begin
         bus.coef_wr = 1'b1;
         bus.coef_addr = IDX_W'(wr_addr);
         bus.coef_data = 18'(wr_val);
      end
      step();
      bus.in_valid = 1'b0;
      bus.in_data = 25'($urandom);
      bus.coef_wr = 1'b0;
      if (wr_mode == 1) mcoef[wr_addr] = sext18(wr_val);
      hist.push_front(longint'(d25));
      if (hist.size() > NTAPS) void'(hist.pop_back());
      exp = model_result(clamped);
      if (clamped) sat_model = 1'b1;

      checkOutput("run0_mac_a", 48'(bus.mac_a), 48'(d25));
      checkOutput("run0_mac_b", 48'(bus.mac_b), 48'(18'(mcoef[0])));
      checkOutput("run0_mac_c", bus.mac_c, 48'(0));
      checkOutput("run_coef_busy", 48'(bus.coef_busy), 48'(1));
      if (wr_mode == 2) begin
         bus.coef_wr = 1'b1;
         bus.coef_addr = IDX_W'(wr_addr);
         bus.coef_data = 18'(wr_val);
      end

      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 4 * NTAPS) begin
         step();
         bus.coef_wr = 1'b0;
         lat++;
      end
      if (bus.out_valid !== 1'b1) begin
         miscompares++;
         $error("[TB] FAIL result_timeout: out_valid %b required 1", bus.out_valid);
         return;
      end
      checkOutput("latency", 48'(lat), 48'(NTAPS));

      for (int i = 0; i < stall; i++) begin
         checkOutput("hold_out_data", bus.out_data, exp);
         checkOutput("hold_in_ready", 48'(bus.in_ready), 48'(0));
         bus.in_valid = 1'b1;
         bus.in_data = 25'($urandom);
         step();
      end
      bus.in_valid = 1'b0;
      checkOutput("out_valid", 48'(bus.out_valid), 48'(1));
      checkOutput("out_data", bus.out_data, exp);
`ifdef MACSEQ_SAT_EN
      checkOutput("sat_flag", 48'(bus.sat_flag), 48'(sat_model));
`endif
      got = bus.out_data;
      bus.out_ready = 1'b1;
      step();
      checkOutput("back_idle_in_ready", 48'(bus.in_ready), 48'(1));
      checkOutput("back_idle_out_valid", 48'(bus.out_valid), 48'(0));
   endtask

   // Wall-clock guard so a wedged DUT still produces a verdict
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [47:0] got;
      int          cum [8];
      cum = '{1, 3, 6, 10, 15, 21, 28, 36};
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.coef_wr = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.out_ready = 1'b1;

      $display("[TB] reset and idle checks");
      applyReset();
      checkReset();
      step();
      checkOutput("idle_in_ready", 48'(bus.in_ready), 48'(1));

      $display("[TB] unit coefficients, running sums");
      for (int i = 0; i < NTAPS; i++) writeCoef(i, 1);
      for (int i = 0; i < NTAPS; i++) begin
         applyStimulus(i + 1, 0, 0, 0, 0, got);
         checkOutput("cumsum_const", got, 48'(cum[i]));
      end

      $display("[TB] single and two-tap filters");
      for (int i = 1; i < NTAPS; i++) writeCoef(i, 0);
      writeCoef(0, 5);
      applyStimulus(-3, 0, 0, 0, 0, got);
      checkOutput("tap0_const", got, 48'(longint'(-15)));
      writeCoef(1, -2);
      applyStimulus(4, 0, 0, 0, 0, got);
      checkOutput("tap01_const", got, 48'(longint'(26)));

      $display("[TB] coefficient write while busy is ignored");
      applyStimulus(7, 0, 2, 0, 100, got);
      applyStimulus(1, 0, 0, 0, 0, got);
      checkOutput("busy_wr_const", got, 48'(longint'(-9)));

      $display("[TB] output back-pressure");
      applyStimulus(2, 20, 0, 0, 0, got);
      applyStimulus(3, 0, 0, 0, 0, got);
      checkOutput("after_stall_const", got, 48'(longint'(11)));

      $display("[TB] coefficient write in the accept cycle");
      applyStimulus(10, 0, 1, 2, 3, got);

      $display("[TB] reset in the middle of a run");
      bus.in_data = 25'(777);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      checkOutput("pre_rst_busy", 48'(bus.coef_busy), 48'(1));
      applyReset();
      checkReset();
      writeCoef(0, 9);
      writeCoef(1, 11);
      applyStimulus(-6, 0, 0, 0, 0, got);
      checkOutput("post_rst_const", got, 48'(longint'(-54)));

      $display("[TB] randomized samples and coefficients");
      for (int n = 0; n < 24; n++) begin
         int nwr;
         nwr = $urandom_range(0, 2);
         for (int w = 0; w < nwr; w++) begin
            writeCoef($urandom_range(0, NTAPS - 1), sext18(int'($urandom)));
         end
         applyStimulus(rnd25(), $urandom_range(0, 3), $urandom_range(0, 2),
                       $urandom_range(0, NTAPS - 1), sext18(int'($urandom)), got);
      end

`ifdef MACSEQ_SAT_EN
      $display("[TB] saturation");
      applyReset();
      for (int i = 0; i < NTAPS; i++) writeCoef(i, 131071);
      for (int i = 0; i < NTAPS; i++) begin
         applyStimulus(16777215, 0, 0, 0, 0, got);
      end
      checkOutput("sat_const", got, 48'(longint'(2147483647)));
      step();
      checkOutput("sat_flag_held", 48'(bus.sat_flag), 48'(1));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mac_tap_sequencer.md
Name: mac_tap_sequencer

Overview:
- Time-multiplexes one combinational 25x18+48 MAC datapath across NTAPS FIR taps for one microphone channel in the beamformer DSP chain.
- Holds a sample delay line and a coefficient bank.
- Accepts one sample per valid/ready handshake and steps through one tap per clock on the shared MAC.
- Presents the 48-bit filtered result through a valid/ready output.

Parameters:
- NTAPS, 8, number of taps; power of two, 2..64.
- IDX_W, $clog2(NTAPS), width of tap and pointer indices.
- SAT_W, 32, saturation width; used only when MACSEQ_SAT_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_data  in  25  signed sample.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  IDX_W  coefficient index.
- coef_data  in  18  signed coefficient.
- coef_busy  out  1  high when not IDLE; coefficient writes are ignored.
- mac_a  out  25  MAC operand a (sample).
- mac_b  out  18  MAC operand b (coefficient).
- mac_c  out  48  MAC addend (accumulator).
- mac_out  in  48  MAC result, combinational: a*b+c in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  48  signed filter result.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - State goes to IDLE.
  - wr_ptr, base, k and acc are cleared to 0.
  - All delay-line entries and all coefficients are cleared to 0.
  - Outputs after reset: in_ready=1, coef_busy=0, out_valid=0, out_data=0, mac_a=0, mac_b=0, mac_c=0.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid: write in_data to sample[wr_ptr], set base<=wr_ptr, wr_ptr<=wr_ptr+1 (mod NTAPS), k<=0, acc<=0, then go to RUN.
  - coef_wr writes coef[coef_addr]<=coef_data.
  - If coef_wr and a sample accept occur in the same IDLE cycle, both happen; the new coefficient is used by that run.
- RUN:
  - in_ready=0.
  - Operands: mac_a=sample[(base-k) mod NTAPS], mac_b=coef[k], mac_c=acc.
  - Each cycle: acc<=mac_out, k<=k+1.
  - When k==NTAPS-1: go to DONE after that cycle's accumulate.
  - Exactly NTAPS RUN cycles per sample.
- DONE:
  - out_valid=1, out_data=acc; both are held stable until out_ready.
  - When out_valid && out_ready: go to IDLE.
  - in_ready=0, so there is no overlap of a new sample with an unconsumed result.
- Operands outside RUN: mac_a, mac_b and mac_c are driven 0 in IDLE and DONE.
- Result: acc = sum over k=0..NTAPS-1 of coef[k]*x[n-k], where x[n] is the newest sample.
- Arithmetic: signed throughout; products are sign-extended to 48 bits. Accumulator wrap-around is two's complement (the MAC does not saturate).
- Latency: sample accepted at edge T; RUN occupies cycles T+1..T+NTAPS; out_valid is asserted in cycle T+NTAPS+1.
- Throughput: one sample per NTAPS+2 cycles with out_ready held at 1.
- Delay line: wraps modulo NTAPS; older samples are overwritten.
- coef_busy = (state != IDLE). coef_wr while busy has no effect.
- in_data is ignored unless in_valid && in_ready.

Optional Feature:
- Macro: MACSEQ_SAT_EN.
- Defined:
  - out_data = acc clamped to [-2^(SAT_W-1), 2^(SAT_W-1)-1], sign-extended to 48 bits.
  - Adds output port sat_flag (1 bit): sticky, set when a clamp occurs at DONE entry, cleared by rst only.
- Undefined:
  - out_data = acc unmodified.
  - No sat_flag port.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, mac_a=mac_b=mac_c=0, coef_busy=0.
- coef[k]=1 for all k, NTAPS=8; feed samples 1..8 with out_ready=1 -> outputs 1,3,6,10,15,21,28,36; out_valid asserted 9 cycles after each accept.
- coef[0]=5, others 0; feed -3 -> out_data=-15. Then coef[1]=-2 with coef[0]=5; feed 4 -> out_data = 5*4 + (-2)*(-3) = 26.
- Hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, a second in_valid is not accepted; release -> IDLE next cycle.
- coef_wr during RUN (addr 0, data 100) -> coef[0] unchanged, verified on the next sample's result. Also assert rst at RUN cycle 3 -> IDLE with all outputs at reset values, and the next result uses the cleared delay line.
- MACSEQ_SAT_EN, SAT_W=32: coef=131071 and samples 16777215 for all 8 taps -> out_data=2147483647, sat_flag=1 and held set.
